// File: rtl/inst_fetch_bpred_pkg.sv
// Shared constants for the fetch stage: bubble instruction, counter encodings, counter update rule.
// Counter width depends on BPRED_2BIT_EN: 2-bit saturating when defined, 1-bit last-outcome otherwise.
package inst_fetch_bpred_pkg;

  localparam logic [31:0] INST_FLUSH = 32'h0000_0013;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

`ifdef BPRED_2BIT_EN
  localparam int CTR_W = 2;
  localparam logic [CTR_W-1:0] CTR_ALLOC = BP_WT;
`else
  localparam int CTR_W = 1;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr, input logic taken);
`ifdef BPRED_2BIT_EN
    if (taken)
      return (ctr == BP_ST) ? BP_ST : ctr + 2'd1;
    else
      return (ctr == BP_SNT) ? BP_SNT : ctr - 2'd1;
`else
    return (ctr == ctr) ? taken : taken;
`endif
  endfunction

endpackage

// File: rtl/inst_fetch_bpred_btb.sv
// Direct-mapped branch target buffer with per-entry direction counters (module fetch_btb).
// Lookup is combinational on registered contents, so a same-cycle update is seen only next cycle.
module fetch_btb
  import inst_fetch_bpred_pkg::*;
#(
  parameter int BTB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        taken,
  output logic [31:0] target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]       tag_r    [BTB_ENTRIES];
  logic [31:0]            target_r [BTB_ENTRIES];
  logic [CTR_W-1:0]       ctr_r    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [3:0]       unused_pc_bits;

  assign unused_pc_bits = {lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  assign hit    = valid_r[lk_idx] && (tag_r[lk_idx] == lk_tag);
  assign taken  = hit && ctr_r[lk_idx][CTR_W-1];
  assign target = target_r[lk_idx];

  assign up_hit = valid_r[up_idx] && (tag_r[up_idx] == up_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (upd_en && !up_hit && upd_taken) begin
      valid_r[up_idx] <= 1'b1;
    end
  end

  // Payload fields carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!rst && upd_en) begin
      if (up_hit) begin
        ctr_r[up_idx] <= ctr_next(ctr_r[up_idx], upd_taken);
        if (upd_taken)
          target_r[up_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_r[up_idx]    <= up_tag;
        target_r[up_idx] <= upd_target;
        ctr_r[up_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_bpred.sv
// Fetch stage: PC register, next-PC selection (redirect > stall > prediction) and IF/ID registers.
// Predictor flavour selected by BPRED_2BIT_EN (see package).
module inst_fetch_bpred
  import inst_fetch_bpred_pkg::*;
#(
  parameter int          BTB_ENTRIES = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        if_stall,
  input  logic        if_flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc_i,
  input  logic        bp_update,
  input  logic [31:0] bp_update_pc_i,
  input  logic        bp_update_taken,
  input  logic [31:0] bp_update_target_i,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_addr_o,
  output logic        inst_ce_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        branch_pred_o,
  output logic [31:0] pred_target_o
);

  logic [31:0] pc_r;
  logic [31:0] pc_next;
  logic [31:0] pred_pc;
  logic        btb_hit;
  logic        pred_taken;
  logic [31:0] btb_target;
  logic        unused_hit;

  assign unused_hit = btb_hit;

  fetch_btb #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (pc_r),
    .hit       (btb_hit),
    .taken     (pred_taken),
    .target    (btb_target),
    .upd_en    (bp_update),
    .upd_pc    (bp_update_pc_i),
    .upd_taken (bp_update_taken),
    .upd_target(bp_update_target_i)
  );

  assign pred_pc = pred_taken ? btb_target : pc_r + 32'd4;

  always_comb begin
    pc_next = pred_pc;
    if (redirect)
      pc_next = redirect_pc_i;
    else if (pc_stall)
      pc_next = pc_r;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc_r <= RESET_PC;
    else
      pc_r <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst || (!if_stall && if_flush)) begin
      inst_o        <= INST_FLUSH;
      pc_o          <= '0;
      branch_pred_o <= 1'b0;
      pred_target_o <= '0;
    end else if (!if_stall) begin
      inst_o        <= inst_i;
      pc_o          <= pc_r;
      branch_pred_o <= pred_taken;
      pred_target_o <= pred_pc;
    end
  end

  assign inst_addr_o = pc_r;
  assign inst_ce_o   = 1'b1;

endmodule
